mult_tile_scheduler: RTL and testbench

Controller that sequences the multiplication_baseline datapath (DIM_A inputs x DIM_C weights -> DIM_C x DIM_A products) over one job of N input vectors.
- Per job: latches a weight set, accepts input vectors over a valid/ready stream, issues them to the fixed-latency multiplier and tracks them in flight.
- Buffers results in a small output FIFO with credit-based flow control and signals job completion.
- Sits between the input/weight feeders and the downstream accumulator/writeback.

---
 rtl/mult_tile_scheduler.sv | 163 ++++++++++++++++
 tb/tb_mult_tile_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_tile_scheduler.sv
// Job sequencer for the multiplication_baseline datapath: latches a weight set, streams
// input vectors into the fixed-latency multiplier and buffers products in a credited FIFO.
module mult_tile_scheduler #(
    parameter int DIM_A        = 8,
    parameter int DIM_C        = 1,
    parameter int INPUT_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 12,
    parameter int MULT_LATENCY = 2,
    parameter int OUT_DEPTH    = 4,
    parameter int MAX_VECS     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$clog2(MAX_VECS+1)-1:0]      num_vecs,
    input  logic [DIM_C*WEIGHT_WIDTH-1:0]      weight_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DIM_A*INPUT_WIDTH-1:0]       in_data,
    output logic                               mul_enable,
    output logic [DIM_A*INPUT_WIDTH-1:0]       mul_in,
    output logic [DIM_C*WEIGHT_WIDTH-1:0]      mul_weight,
    input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   mul_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   out_data,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done
);
    localparam int VW  = $clog2(MAX_VECS + 1);
    localparam int FCW = $clog2(OUT_DEPTH + 1);
    localparam int PW  = $clog2(OUT_DEPTH);
    localparam int IW  = $clog2(MULT_LATENCY + 1);
    localparam int DOW = DIM_C * DIM_A * ACC_WIDTH;

    localparam logic [VW-1:0]  ONE_V    = VW'(1);
    localparam logic [FCW-1:0] ONE_F    = FCW'(1);
    localparam logic [FCW-1:0] FULL_F   = FCW'(OUT_DEPTH);
    localparam logic [PW-1:0]  ONE_P    = PW'(1);
    localparam logic [PW-1:0]  LAST_PTR = PW'(OUT_DEPTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                      state;
    logic [VW-1:0]                   num_vecs_q;
    logic [VW-1:0]                   issued;
    logic [DIM_C*WEIGHT_WIDTH-1:0]   weight_q;
    logic [MULT_LATENCY-1:0]         tag_vld;
    logic [MULT_LATENCY-1:0]         tag_last;
    logic [DOW-1:0]                  fifo_mem [OUT_DEPTH];
    logic [OUT_DEPTH-1:0]            fifo_last;
    logic [PW-1:0]                   wr_ptr;
    logic [PW-1:0]                   rd_ptr;
    logic [FCW-1:0]                  fifo_count;
    logic [IW-1:0]                   inflight_count;
    logic                            credit_ok;
    logic                            issue;
    logic                            last_issue;
    logic                            push;
    logic                            pop;
    logic                            drained;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < MULT_LATENCY; i++) begin
            inflight_count = inflight_count + IW'(tag_vld[i]);
        end
    end

    // Credits count FIFO entries plus results still inside the multiplier; a same-cycle pop is not credited.
    assign credit_ok  = (32'(fifo_count) + 32'(inflight_count)) < OUT_DEPTH;
    assign in_ready   = (state == S_RUN) && (issued < num_vecs_q) && credit_ok;
    assign issue      = in_valid && in_ready;
    assign last_issue = (issued + ONE_V) == num_vecs_q;
    assign mul_in     = issue ? in_data : '0;
    assign mul_enable = (state == S_LOAD_W) || (state == S_RUN) || (state == S_DRAIN);
    assign mul_weight = weight_q;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    assign push      = tag_vld[MULT_LATENCY-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr];

    // Nothing in flight means no push this cycle, so popping the single remaining entry empties the FIFO.
    assign drained = (inflight_count == '0) &&
                     ((fifo_count == '0) || ((fifo_count == ONE_F) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            num_vecs_q <= '0;
            issued     <= '0;
            weight_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_vecs_q <= num_vecs;
                        weight_q   <= weight_in;
                        issued     <= '0;
                        state      <= (num_vecs == '0) ? S_DONE : S_LOAD_W;
                    end
                end
                S_LOAD_W: state <= S_RUN;
                S_RUN: begin
                    if (issue) issued <= issued + ONE_V;
                    if (issued == num_vecs_q) state <= S_DRAIN;
                end
                S_DRAIN: if (drained) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue tags ride alongside the multiplier pipeline; the last stage marks mul_out as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            tag_vld[0]  <= issue;
            tag_last[0] <= issue && last_issue;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            assert (!(push && !pop && (fifo_count == FULL_F)));
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ONE_P;
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ONE_P;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE_F;
                2'b01:   fifo_count <= fifo_count - ONE_F;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr]  <= mul_out;
            fifo_last[wr_ptr] <= tag_last[MULT_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_mult_tile_scheduler.sv
// Directed bench for mult_tile_scheduler with a two-stage multiplier stub behind the datapath ports.
module tb_mult_tile_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_vecs;
    logic [7:0]  weight_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mul_enable;
    logic [31:0] mul_in;
    logic [7:0]  mul_weight;
    logic [95:0] mul_out;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mult_tile_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .weight_in(weight_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_enable(mul_enable), .mul_in(mul_in), .mul_weight(mul_weight), .mul_out(mul_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [95:0] prod(input logic [31:0] d, input logic [7:0] w);
        logic [95:0] r;
        for (int a = 0; a < 8; a++) r[a*12 +: 12] = {8'd0, d[a*4 +: 4]} * {4'd0, w};
        return r;
    endfunction

    // Multiplier stub: mul_in sampled at the issue edge appears on mul_out two cycles later.
    logic [95:0] p1 = '0;
    logic [95:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= prod(mul_in, mul_weight);
        p2 <= p1;
    end
    assign mul_out = p2;

    function automatic logic [31:0] vec_data(input int i);
        logic [31:0] d;
        for (int a = 0; a < 8; a++) d[a*4 +: 4] = 4'((i + a + 1) % 16);
        return d;
    endfunction

    function automatic logic [95:0] exp_vec(input int i, input int w);
        logic [95:0] r;
        for (int a = 0; a < 8; a++) r[a*12 +: 12] = 12'(((i + a + 1) % 16) * w);
        return r;
    endfunction

    int          iss_cyc[$];
    int          pop_cyc[$];
    logic [95:0] pop_dat[$];
    bit          pop_lst[$];
    int          done_cyc, done_cnt, rdy_cnt, start_cyc, iss_at_release;
    bit          busy_s1, busy_after, en_s1, timed_out;
    logic [7:0]  w_s1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int nv, input logic [7:0] w, input bit vary,
                           input logic [31:0] fixed, input int hold);
        iss_cyc.delete(); pop_cyc.delete(); pop_dat.delete(); pop_lst.delete();
        done_cyc = -1; done_cnt = 0; rdy_cnt = 0; timed_out = 1'b1; iss_at_release = 0;
        start = 1'b1; num_vecs = nv[4:0]; weight_in = w; in_valid = 1'b0; in_data = '0;
        out_ready = (hold == 0);
        #1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            in_valid  = 1'b1;
            in_data   = vary ? vec_data(iss_cyc.size()) : fixed;
            out_ready = (k >= hold);
            if (k == hold) iss_at_release = iss_cyc.size();
            #1;
            if (k == 0) begin
                en_s1 = mul_enable; w_s1 = mul_weight; busy_s1 = busy;
            end
            if (in_ready) rdy_cnt++;
            if (in_valid && in_ready) iss_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc); pop_dat.push_back(out_data); pop_lst.push_back(out_last);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            step();
            if (done_cyc >= 0) begin
                in_valid = 1'b0;
                #1;
                busy_after = busy;
                timed_out = 1'b0;
                break;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL job_timeout: done not seen, expected within 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_vecs = '0; weight_in = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mul_enable, out_valid, out_last, busy, done} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                               {in_ready, mul_enable, out_valid, out_last, busy, done});
        end
        checks++;
        if (mul_weight !== 8'h00) begin
            errors++; $display("FAIL reset_weight: got %h expected 00", mul_weight);
        end
        checks++;
        if (out_data !== 96'h0) begin
            errors++; $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        checks++;
        if (mul_in !== 32'h0) begin
            errors++; $display("FAIL reset_mul_in: got %h expected 0", mul_in);
        end
        step();
    endtask

    task automatic test_basic();
        logic [95:0] exp;
        exp = {12'd15, 12'd14, 12'd13, 12'd12, 12'd11, 12'd10, 12'd9, 12'd8};
        run_job(3, 8'd1, 1'b0, {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8}, 0);
        checks++;
        if (en_s1 !== 1'b1 || w_s1 !== 8'd1) begin
            errors++; $display("FAIL basic_load_w: en=%b w=%0d expected en=1 w=1", en_s1, w_s1);
        end
        checks++;
        if (pop_cyc.size() != 3 || iss_cyc.size() != 3) begin
            errors++; $display("FAIL basic_count: pops=%0d issues=%0d expected 3/3",
                               pop_cyc.size(), iss_cyc.size());
        end
        for (int i = 0; i < 3 && i < pop_cyc.size() && i < iss_cyc.size(); i++) begin
            checks++;
            if (pop_dat[i] !== exp) begin
                errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, pop_dat[i], exp);
            end
            checks++;
            if (pop_cyc[i] - iss_cyc[i] != 3) begin
                errors++; $display("FAIL basic_latency[%0d]: got %0d expected 3", i,
                                   pop_cyc[i] - iss_cyc[i]);
            end
            checks++;
            if (pop_lst[i] !== (i == 2)) begin
                errors++; $display("FAIL basic_last[%0d]: got %b expected %b", i, pop_lst[i], i == 2);
            end
        end
        checks++;
        if (pop_cyc.size() == 0 || done_cyc != pop_cyc[pop_cyc.size()-1] + 1) begin
            errors++; $display("FAIL basic_done_time: got cycle %0d expected one after last pop", done_cyc);
        end
        checks++;
        if (done_cnt != 1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL basic_done_busy: done_cnt=%0d busy_after=%b expected 1/0",
                               done_cnt, busy_after);
        end
    endtask

    task automatic test_max_product();
        int lasts;
        lasts = 0;
        run_job(16, 8'd255, 1'b0, 32'hFFFF_FFFF, 0);
        checks++;
        if (iss_cyc.size() != 16 || rdy_cnt != 16) begin
            errors++; $display("FAIL max_issues: issues=%0d ready_cycles=%0d expected 16/16",
                               iss_cyc.size(), rdy_cnt);
        end
        checks++;
        if (iss_cyc.size() == 16 && iss_cyc[15] - iss_cyc[0] != 15) begin
            errors++; $display("FAIL max_no_bubble: span=%0d expected 15", iss_cyc[15] - iss_cyc[0]);
        end
        checks++;
        if (pop_dat.size() != 16) begin
            errors++; $display("FAIL max_pops: got %0d expected 16", pop_dat.size());
        end
        for (int i = 0; i < pop_dat.size(); i++) begin
            if (pop_lst[i]) lasts++;
            checks++;
            if (pop_dat[i] !== {8{12'hEF1}}) begin
                errors++; $display("FAIL max_data[%0d]: got %h expected all lanes ef1", i, pop_dat[i]);
            end
        end
        checks++;
        if (lasts != 1 || pop_lst.size() != 16 || pop_lst[15] !== 1'b1) begin
            errors++; $display("FAIL max_last: last_flags=%0d expected 1 on entry 15", lasts);
        end
    endtask

    task automatic test_backpressure();
        run_job(8, 8'd3, 1'b1, 32'h0, 12);
        checks++;
        if (iss_at_release != 4) begin
            errors++; $display("FAIL bp_credit_stop: issues=%0d expected 4", iss_at_release);
        end
        checks++;
        if (pop_dat.size() != 8 || iss_cyc.size() != 8) begin
            errors++; $display("FAIL bp_count: pops=%0d issues=%0d expected 8/8",
                               pop_dat.size(), iss_cyc.size());
        end
        for (int i = 0; i < pop_dat.size(); i++) begin
            checks++;
            if (pop_dat[i] !== exp_vec(i, 3) || pop_lst[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_order[%0d]: got %h last=%b expected %h last=%b",
                                   i, pop_dat[i], pop_lst[i], exp_vec(i, 3), i == 7);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_empty_job();
        run_job(0, 8'd7, 1'b0, 32'h1234_5678, 0);
        checks++;
        if (rdy_cnt != 0 || pop_dat.size() != 0) begin
            errors++; $display("FAIL empty_activity: ready=%0d pops=%0d expected 0/0",
                               rdy_cnt, pop_dat.size());
        end
        checks++;
        if (done_cyc != start_cyc + 1 || done_cnt != 1) begin
            errors++; $display("FAIL empty_done: at %0d count %0d expected at %0d count 1",
                               done_cyc, done_cnt, start_cyc + 1);
        end
        checks++;
        if (busy_s1 !== 1'b1 || busy_after !== 1'b0 || en_s1 !== 1'b0) begin
            errors++; $display("FAIL empty_busy: busy=%b after=%b en=%b expected 1/0/0",
                               busy_s1, busy_after, en_s1);
        end
    endtask

    task automatic test_abuse();
        int stray;
        stray = 0;
        start = 1'b1; num_vecs = 5'd6; weight_in = 8'd2; in_valid = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = vec_data(0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL abuse_first_ready: got %b expected 1", in_ready);
        end
        step();
        in_data = vec_data(1); start = 1'b1; num_vecs = 5'd1; weight_in = 8'd9;
        step();
        start = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (mul_weight !== 8'd2 || in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL abuse_start_ignored: w=%0d ready=%b busy=%b expected 2/1/1",
                               mul_weight, in_ready, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mul_enable, out_valid, out_last, busy, done} !== 6'b0 ||
            mul_weight !== 8'h0 || out_data !== 96'h0 || mul_in !== 32'h0) begin
            errors++; $display("FAIL abuse_reset: ctrl=%b w=%h data=%h expected all zero",
                               {in_ready, mul_enable, out_valid, out_last, busy, done},
                               mul_weight, out_data);
        end
        for (int k = 0; k < 8; k++) begin
            if (out_valid || done || busy) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL abuse_no_stray: got %0d active cycles expected 0", stray);
        end
        run_job(2, 8'd5, 1'b1, 32'h0, 0);
        checks++;
        if (pop_dat.size() != 2 || done_cnt != 1) begin
            errors++; $display("FAIL abuse_rerun_count: pops=%0d done=%0d expected 2/1",
                               pop_dat.size(), done_cnt);
        end
        for (int i = 0; i < pop_dat.size(); i++) begin
            checks++;
            if (pop_dat[i] !== exp_vec(i, 5)) begin
                errors++; $display("FAIL abuse_rerun_data[%0d]: got %h expected %h",
                                   i, pop_dat[i], exp_vec(i, 5));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        step();
        test_max_product();
        step();
        test_backpressure();
        step();
        test_empty_job();
        step();
        test_abuse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
